// File: rtl/axil_order_dispatcher.sv
// rtl/axil_order_dispatcher.sv - AXI4-Lite master that drains a FIFO of (addr, data) orders into register writes
// Ports: m00_axi_aclk/m00_axi_areset clock and sync active-high reset; ord_valid/ord_ready/ord_addr/ord_data
// order stream in; m00_axi_aw*/w*/b*/ar*/r* AXI4-Lite master channels; busy, fifo_level, sent_count,
// err_bresp, err_timeout progress and sticky error status.
module axil_order_dispatcher #(
    parameter int                         AXIL_DATA_WIDTH = 32,
    parameter int                         AXIL_ADDR_WIDTH = 8,
    parameter int                         FIFO_DEPTH      = 16,
    parameter logic [AXIL_ADDR_WIDTH-1:0] GATE_ADDR       = 8'h48,
    parameter logic [AXIL_ADDR_WIDTH-1:0] STATUS_ADDR     = 8'h4c,
    parameter int                         POLL_GAP        = 4,
    parameter int                         POLL_TIMEOUT    = 1024
) (
    input  logic                             m00_axi_aclk,
    input  logic                             m00_axi_areset,
    input  logic                             ord_valid,
    output logic                             ord_ready,
    input  logic [AXIL_ADDR_WIDTH-1:0]       ord_addr,
    input  logic [AXIL_DATA_WIDTH-1:0]       ord_data,
    output logic [AXIL_ADDR_WIDTH-1:0]       m00_axi_awaddr,
    output logic [2:0]                       m00_axi_awprot,
    output logic                             m00_axi_awvalid,
    input  logic                             m00_axi_awready,
    output logic [AXIL_DATA_WIDTH-1:0]       m00_axi_wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0]     m00_axi_wstrb,
    output logic                             m00_axi_wvalid,
    input  logic                             m00_axi_wready,
    input  logic [1:0]                       m00_axi_bresp,
    input  logic                             m00_axi_bvalid,
    output logic                             m00_axi_bready,
    output logic [AXIL_ADDR_WIDTH-1:0]       m00_axi_araddr,
    output logic [2:0]                       m00_axi_arprot,
    output logic                             m00_axi_arvalid,
    input  logic                             m00_axi_arready,
    input  logic [AXIL_DATA_WIDTH-1:0]       m00_axi_rdata,
    input  logic [1:0]                       m00_axi_rresp,
    input  logic                             m00_axi_rvalid,
    output logic                             m00_axi_rready,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic [31:0]                      sent_count,
    output logic                             err_bresp,
    output logic                             err_timeout
);
    localparam int                PW         = $clog2(FIFO_DEPTH);
    localparam int                LW         = PW + 1;
    localparam int                EW         = AXIL_ADDR_WIDTH + AXIL_DATA_WIDTH;
    localparam logic [LW-1:0]     FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [31:0]       GAP_LAST   = (POLL_GAP > 0) ? 32'(POLL_GAP - 1) : 32'd0;
    localparam logic [31:0]       TIMEOUT_N  = 32'(POLL_TIMEOUT);
    localparam logic [1:0]        RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {IDLE, POLL_AR, POLL_R, POLL_WAIT, WR, WR_B} state_t;

    state_t                       state_q;
    logic [EW-1:0]                mem_q [FIFO_DEPTH];
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                level_q, level_d;
    logic                         ord_ready_q, ord_ready_d;
    logic                         push, pop;
    logic [EW-1:0]                head;
    logic [AXIL_ADDR_WIDTH-1:0]   cur_addr_q;
    logic [AXIL_DATA_WIDTH-1:0]   cur_data_q;
    logic [31:0]                  poll_cnt_q, gap_cnt_q, sent_q;
    logic                         awvalid_q, wvalid_q, arvalid_q, rready_q, bready_q;
    logic                         err_bresp_q, err_timeout_q;

    // ord_ready is registered so it never depends on this cycle's pop: a full FIFO stays closed
    // for the cycle in which it frees a slot.
    assign push = ord_valid && ord_ready_q;
    assign pop  = (state_q == IDLE) && (level_q != '0);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (!push && pop) level_d = level_q - 1'b1;
        ord_ready_d = (level_d != FULL_LEVEL);
    end

    always_ff @(posedge m00_axi_aclk) begin
        if (push) mem_q[wr_ptr_q] <= {ord_addr, ord_data};
    end

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ord_ready_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ord_ready_q <= ord_ready_d;
        end
    end

    // Each valid is raised on entry to its state and only ever cleared by its own handshake,
    // so no valid depends combinationally on a ready.
    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            cur_data_q    <= '0;
            poll_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            sent_q        <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            bready_q      <= 1'b0;
            err_bresp_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        {cur_addr_q, cur_data_q} <= head;
                        poll_cnt_q <= '0;
                        if (head[EW-1 -: AXIL_ADDR_WIDTH] == GATE_ADDR) begin
                            state_q   <= POLL_AR;
                            arvalid_q <= 1'b1;
                        end else begin
                            state_q   <= WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end
                    end
                end
                POLL_AR: begin
                    if (m00_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= POLL_R;
                    end
                end
                POLL_R: begin
                    if (m00_axi_rvalid) begin
                        rready_q   <= 1'b0;
                        poll_cnt_q <= poll_cnt_q + 32'd1;
                        if (m00_axi_rresp == RESP_OKAY && m00_axi_rdata != '0) begin
                            state_q   <= WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else if (TIMEOUT_N != 32'd0 && poll_cnt_q + 32'd1 == TIMEOUT_N) begin
                            err_timeout_q <= 1'b1;
                            state_q       <= IDLE;
                        end else if (POLL_GAP == 0) begin
                            state_q   <= POLL_AR;
                            arvalid_q <= 1'b1;
                        end else begin
                            state_q   <= POLL_WAIT;
                            gap_cnt_q <= '0;
                        end
                    end
                end
                POLL_WAIT: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q   <= POLL_AR;
                        arvalid_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 32'd1;
                    end
                end
                WR: begin
                    if (m00_axi_awready) awvalid_q <= 1'b0;
                    if (m00_axi_wready)  wvalid_q  <= 1'b0;
                    // A channel is done if it already handshook earlier or handshakes now.
                    if ((!awvalid_q || m00_axi_awready) && (!wvalid_q || m00_axi_wready)) begin
                        state_q  <= WR_B;
                        bready_q <= 1'b1;
                    end
                end
                WR_B: begin
                    if (m00_axi_bvalid) begin
                        bready_q <= 1'b0;
                        sent_q   <= sent_q + 32'd1;
                        if (m00_axi_bresp != RESP_OKAY) err_bresp_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ord_ready       = ord_ready_q;
    assign m00_axi_awaddr  = cur_addr_q;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = cur_data_q;
    assign m00_axi_wstrb   = '1;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = bready_q;
    assign m00_axi_araddr  = STATUS_ADDR;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = rready_q;
    assign busy            = (level_q != '0) || (state_q != IDLE);
    assign fifo_level      = level_q;
    assign sent_count      = sent_q;
    assign err_bresp       = err_bresp_q;
    assign err_timeout     = err_timeout_q;

endmodule
